// File: rtl/smiley_hit_edge_detector.sv
// smiley_hit_edge_detector
//   Finds pixels where the smiley and an obstacle are drawn together and
//   classifies each one by the smiley edge band it falls in. The edge codes
//   are ORed over a frame and reported once, at the next frame boundary.
//   After a report, a cooldown of whole frames stops the mover from
//   negating a speed twice for the same contact.
//
//   State table:
//     ARMED    | idle, waiting for the first overlapping pixel of a frame
//     HIT_SEEN | overlap seen this frame, accumulating edge codes
//     REPORT   | single cycle: collision pulse, count update, clear acc
//     COOLDOWN | overlaps ignored until the cooldown frames have elapsed
//
// Ports
//   clk            system clock
//   resetN         asynchronous active-low reset
//   startOfFrame   one-cycle pulse per frame
//   pixelX/pixelY  current scan position, unsigned
//   topLeftX/Y     smiley top-left corner, signed
//   smileyDR       smiley drawing request at the scan position
//   obstacleDR     brick/border drawing request at the scan position
//   collision      one-cycle pulse per reported frame
//   HitEdgeCode    {Left, Top, Right, Bottom}, held between reports
//   collisionCount reports since reset, saturating at 255
module smiley_hit_edge_detector #(
  parameter int OBJECT_WIDTH    = 64,
  parameter int OBJECT_HEIGHT   = 64,
  parameter int EDGE_MARGIN     = 4,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        smileyDR,
  input  logic        obstacleDR,
  output logic        collision,
  output logic [3:0]  HitEdgeCode,
  output logic [7:0]  collisionCount
);

  localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic signed [11:0] ZERO   = '0;
  localparam logic signed [11:0] MARGIN = 12'(EDGE_MARGIN);
  localparam logic signed [11:0] R_LO   = 12'(OBJECT_WIDTH - EDGE_MARGIN);
  localparam logic signed [11:0] R_HI   = 12'(OBJECT_WIDTH);
  localparam logic signed [11:0] B_LO   = 12'(OBJECT_HEIGHT - EDGE_MARGIN);
  localparam logic signed [11:0] B_HI   = 12'(OBJECT_HEIGHT);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    HIT_SEEN = 2'd1,
    REPORT   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  // ---------------- stage 1: offset and edge classification ----------------
  logic signed [11:0] off_x;
  logic signed [11:0] off_y;
  logic [3:0]         code_d;
  logic [3:0]         code_q;
  logic               overlap_q;

  // pixel is zero-extended, top-left is sign-extended
  assign off_x = $signed({1'b0, pixelX}) - $signed({topLeftX[10], topLeftX});
  assign off_y = $signed({1'b0, pixelY}) - $signed({topLeftY[10], topLeftY});

  always_comb begin
    code_d    = 4'b0000;
    code_d[3] = (off_x >= ZERO) && (off_x < MARGIN);
    code_d[2] = (off_y >= ZERO) && (off_y < MARGIN);
    code_d[1] = (off_x >= R_LO) && (off_x < R_HI);
    code_d[0] = (off_y >= B_LO) && (off_y < B_HI);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      overlap_q <= 1'b0;
      code_q    <= 4'b0000;
    end else begin
      // masking at the frame pulse keeps the frame boundary unambiguous
      overlap_q <= smileyDR & obstacleDR & ~startOfFrame;
      code_q    <= code_d;
    end
  end

  // ---------------- stage 2: per-frame report FSM ----------------
  state_t     state, state_next;
  logic [3:0] acc, acc_next;
  logic [3:0] code_hold_next;
  logic [7:0] count_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= ARMED;
      acc            <= 4'b0000;
      HitEdgeCode    <= 4'b0000;
      collisionCount <= 8'd0;
      cnt            <= '0;
    end else begin
      state          <= state_next;
      acc            <= acc_next;
      HitEdgeCode    <= code_hold_next;
      collisionCount <= count_next;
      cnt            <= cnt_next;
    end
  end

  always_comb begin
    state_next     = state;
    acc_next       = acc;
    code_hold_next = HitEdgeCode;
    count_next     = collisionCount;
    cnt_next       = cnt;
    case (state)
      ARMED: begin
        if (overlap_q) begin
          state_next = HIT_SEEN;
          acc_next   = code_q;
        end
      end
      HIT_SEEN: begin
        // the last pixel of the frame may land together with the frame pulse
        if (overlap_q) acc_next = acc | code_q;
        if (startOfFrame) begin
          state_next     = REPORT;
          code_hold_next = overlap_q ? (acc | code_q) : acc;
        end
      end
      REPORT: begin
        acc_next = 4'b0000;
        if (collisionCount != 8'hFF) count_next = collisionCount + 8'd1;
        if (COOLDOWN_FRAMES > 0) begin
          state_next = COOLDOWN;
          cnt_next   = CNT_W'(COOLDOWN_FRAMES);
        end else begin
          state_next = ARMED;
        end
      end
      COOLDOWN: begin
        acc_next = 4'b0000;
        if (startOfFrame) begin
          if (cnt == CNT_W'(1)) begin
            state_next = ARMED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end
      default: state_next = ARMED;
    endcase
  end

  assign collision = (state == REPORT);

endmodule

// File: tb/tb_smiley_hit_edge_detector.sv
// Bench for smiley_hit_edge_detector: directed frames for the documented
// scenarios, then randomized frames, checked against a frame-level model.
module tb_smiley_hit_edge_detector;

  localparam int W  = 64;
  localparam int H  = 64;
  localparam int M  = 4;
  localparam int CD = 2;
  localparam int L  = 16;   // cycles per frame

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
  logic        smileyDR, obstacleDR;
  logic        collision;
  logic [3:0]  HitEdgeCode;
  logic [7:0]  collisionCount;

  smiley_hit_edge_detector #(
    .OBJECT_WIDTH(W), .OBJECT_HEIGHT(H), .EDGE_MARGIN(M), .COOLDOWN_FRAMES(CD)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .smileyDR(smileyDR), .obstacleDR(obstacleDR),
    .collision(collision), .HitEdgeCode(HitEdgeCode), .collisionCount(collisionCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int tlx, tly;
  int ev_x[$], ev_y[$];
  bit ev_s[$], ev_o[$];

  // frame-level reference model
  bit         pending;
  logic [3:0] acc_m;
  logic [3:0] exp_code;
  int         exp_count;
  int         cool_m;
  bit         exp_pulse;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_code(input int px, input int py);
    int ox, oy;
    logic l, t, r, b;
    ox = px - tlx;
    oy = py - tly;
    l = (ox >= 0) && (ox < M);
    t = (oy >= 0) && (oy < M);
    r = (ox >= W - M) && (ox < W);
    b = (oy >= H - M) && (oy < H);
    return {l, t, r, b};
  endfunction

  task automatic add_ev(input int x, input int y, input bit s, input bit o);
    ev_x.push_back(x);
    ev_y.push_back(y);
    ev_s.push_back(s);
    ev_o.push_back(o);
  endtask

  task automatic model_reset();
    pending   = 0;
    acc_m     = 4'b0000;
    exp_code  = 4'b0000;
    exp_count = 0;
    cool_m    = 0;
    exp_pulse = 0;
  endtask

  // One frame: frame pulse in step 0, queued pixels in steps 1..L-2,
  // nothing in the last step so no overlap straddles the boundary.
  task automatic run_frame(input bit sof_ovl);
    int x, y;
    bit s, o;
    @(negedge clk);
    chk("collision_step0", {7'b0, collision}, 8'd0);
    startOfFrame = 1'b1;
    topLeftX     = tlx[10:0];
    topLeftY     = tly[10:0];
    pixelX       = tlx[10:0];
    pixelY       = 11'(tly + M);
    smileyDR     = sof_ovl;
    obstacleDR   = sof_ovl;
    exp_pulse = pending;
    if (pending) begin
      exp_code = acc_m;
      if (exp_count < 255) exp_count++;
      cool_m  = CD;
      pending = 0;
      acc_m   = 4'b0000;
    end else if (cool_m > 0) begin
      cool_m--;
    end
    for (int step = 1; step < L; step++) begin
      @(negedge clk);
      chk("collision", {7'b0, collision}, {7'b0, (step == 1) && exp_pulse});
      if (step == 3) begin
        chk("hit_edge_code", {4'b0, HitEdgeCode}, {4'b0, exp_code});
        chk("collision_count", collisionCount, 8'(exp_count));
      end
      startOfFrame = 1'b0;
      if (step <= L - 2 && ev_x.size() > 0) begin
        x = ev_x.pop_front();
        y = ev_y.pop_front();
        s = ev_s.pop_front();
        o = ev_o.pop_front();
        pixelX     = 11'(x);
        pixelY     = 11'(y);
        smileyDR   = s;
        obstacleDR = o;
        if (cool_m == 0 && s && o) begin
          pending = 1;
          acc_m   = acc_m | ref_code(x, y);
        end
      end else begin
        smileyDR   = 1'b0;
        obstacleDR = 1'b0;
      end
    end
    ev_x.delete(); ev_y.delete(); ev_s.delete(); ev_o.delete();
  endtask

  task automatic settle();
    for (int i = 0; i < 6 && (pending || cool_m != 0); i++) run_frame(0);
  endtask

  initial begin
    int n, x, y;
    resetN = 1'b0; startOfFrame = 1'b0; smileyDR = 1'b0; obstacleDR = 1'b0;
    pixelX = '0; pixelY = '0; tlx = 100; tly = 100;
    topLeftX = 11'd100; topLeftY = 11'd100;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_collision", {7'b0, collision}, 8'd0);
    chk("reset_code", {4'b0, HitEdgeCode}, 8'd0);
    chk("reset_count", collisionCount, 8'd0);
    resetN = 1'b1;

    // left edge only
    add_ev(100, 130, 1, 1); run_frame(0);
    run_frame(0);
    chk("t1_code", {4'b0, HitEdgeCode}, 8'b1000);
    chk("t1_count", collisionCount, 8'd1);
    settle();

    // top|right|bottom in one frame
    add_ev(163, 100, 1, 1); add_ev(163, 163, 1, 1); run_frame(0);
    run_frame(0);
    chk("t2_code", {4'b0, HitEdgeCode}, 8'b0111);
    chk("t2_count", collisionCount, 8'd2);
    settle();

    // overlap every frame: pulses spaced by the cooldown
    n = 0;
    for (int f = 0; f < 9; f++) begin
      add_ev(163, 130, 1, 1);
      run_frame(0);
      if (exp_pulse) n++;
    end
    run_frame(0);
    chk("t3_count", collisionCount, 8'd5);
    settle();

    // interior pixel still reports, code 0000 held across an empty frame
    add_ev(130, 130, 1, 1); run_frame(0);
    run_frame(0);
    chk("t4_code", {4'b0, HitEdgeCode}, 8'b0000);
    settle();
    run_frame(0);
    chk("t4_hold", {4'b0, HitEdgeCode}, 8'b0000);
    chk("t4_count", collisionCount, 8'd6);

    // overlap only in the frame-pulse cycle is ignored
    run_frame(1);
    run_frame(0);
    chk("t5_masked_count", collisionCount, 8'd6);

    // reset in the middle of cooldown
    add_ev(100, 100, 1, 1); run_frame(0);
    run_frame(0);
    @(negedge clk);
    resetN = 1'b0;
    smileyDR = 1'b0; obstacleDR = 1'b0; startOfFrame = 1'b0;
    #1;
    chk("t5_rst_collision", {7'b0, collision}, 8'd0);
    chk("t5_rst_code", {4'b0, HitEdgeCode}, 8'd0);
    chk("t5_rst_count", collisionCount, 8'd0);
    @(negedge clk);
    resetN = 1'b1;
    model_reset();
    add_ev(163, 130, 1, 1); run_frame(0);
    run_frame(0);
    chk("t5_after_code", {4'b0, HitEdgeCode}, 8'b0010);
    chk("t5_after_count", collisionCount, 8'd1);
    settle();

    // negative top-left X
    tlx = -10; tly = 100;
    add_ev(0, 130, 1, 1); add_ev(0, 100, 1, 1); run_frame(0);
    run_frame(0);
    chk("t6_code", {4'b0, HitEdgeCode}, 8'b0100);
    settle();

    // randomized frames
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        tlx = int'($urandom_range(0, 900)) - 40;
        tly = int'($urandom_range(0, 900)) - 40;
      end
      n = $urandom_range(0, 6);
      for (int e = 0; e < n; e++) begin
        x = tlx + int'($urandom_range(0, 79)) - 8;
        y = tly + int'($urandom_range(0, 79)) - 8;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
        add_ev(x, y, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
      run_frame($urandom_range(0, 4) == 0);
    end

    // saturation of the report counter
    tlx = 100; tly = 100;
    for (int f = 0; f < 800; f++) begin
      add_ev(100, 100, 1, 1);
      run_frame(0);
    end
    run_frame(0);
    chk("t6_saturated", collisionCount, 8'd255);
    chk("t6_sat_code", {4'b0, HitEdgeCode}, 8'b1100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
